// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - core bus demux to async SRAM with programmable wait states
// Optional ADDR-phase timeout guarded by MEM_BUS_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_bus_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic [15:0]       CoreData,
    input  logic              ALE,
    input  logic              nME,
    input  logic              nOE,
    input  logic              RnW,
    output logic [15:0]       CoreDataIn,
    output logic              nWait,
    output logic [ADDR_W-1:0] SramAddr,
    output logic [15:0]       SramDout,
    input  logic [15:0]       SramDin,
    output logic              SramnCE,
    output logic              SramnOE,
    output logic              SramnWE,
    output logic              BusErr
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_ACCESS, S_HOLD} state_e;

    localparam logic [3:0] RD_N = 4'(RD_WAIT);
    localparam logic [3:0] WR_N = 4'(WR_WAIT);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              is_rd_q, is_rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dout_q, dout_d;
    logic [15:0]       din_q, din_d;
    logic              nwait_q, nwait_d;
    logic              nce_q, nce_d;
    logic              noe_q, noe_d;
    logic              nwe_q, nwe_d;
    logic              err_q, err_d;
    logic [3:0]        load_n;
    logic              tmo_hit;

    assign load_n = RnW ? RD_N : WR_N;

`ifdef MEM_BUS_TIMEOUT_EN
    logic [3:0] tmo_q, tmo_d;

    // 15th consecutive ADDR edge without nME low gives up on the access
    assign tmo_hit = (state_q == S_ADDR) && nME && (tmo_q == 4'd14);
    assign tmo_d   = (state_q == S_ADDR && state_d == S_ADDR) ? tmo_q + 4'd1 : 4'd0;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) tmo_q <= 4'd0;
        else         tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            is_rd_q <= 1'b0;
            addr_q  <= '0;
            dout_q  <= 16'h0000;
            din_q   <= 16'h0000;
            nwait_q <= 1'b1;
            nce_q   <= 1'b1;
            noe_q   <= 1'b1;
            nwe_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_rd_q <= is_rd_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            din_q   <= din_d;
            nwait_q <= nwait_d;
            nce_q   <= nce_d;
            noe_q   <= noe_d;
            nwe_q   <= nwe_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ALE) state_d = S_ADDR;
            S_ADDR: begin
                if (!nME)         state_d = (RnW && nOE) ? S_IDLE : S_ACCESS;
                else if (tmo_hit) state_d = S_IDLE;
            end
            S_ACCESS: begin
                if (nME)                state_d = S_IDLE;
                else if (cnt_q == 4'd0) state_d = S_HOLD;
            end
            S_HOLD:   if (nME) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        is_rd_d = is_rd_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        din_d   = din_q;
        nwait_d = nwait_q;
        nce_d   = nce_q;
        noe_d   = noe_q;
        nwe_d   = nwe_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (ALE) addr_d = CoreData[ADDR_W-1:0];
            S_ADDR: begin
                if (ALE) addr_d = CoreData[ADDR_W-1:0];
                if (!nME) begin
                    if (RnW && nOE) begin
                        err_d = 1'b1;
                    end else begin
                        nce_d   = 1'b0;
                        is_rd_d = RnW;
                        cnt_d   = load_n;
                        nwait_d = (load_n == 4'd0);
                        if (RnW) begin
                            noe_d = 1'b0;
                        end else begin
                            nwe_d  = 1'b0;
                            dout_d = CoreData;
                        end
                    end
                end else if (tmo_hit) begin
                    err_d = 1'b1;
                end
            end
            S_ACCESS: begin
                if (ALE) err_d = 1'b1;
                if (nME) begin
                    nce_d   = 1'b1;
                    noe_d   = 1'b1;
                    nwe_d   = 1'b1;
                    nwait_d = 1'b1;
                    cnt_d   = 4'd0;
                    err_d   = 1'b1;
                end else if (cnt_q != 4'd0) begin
                    // release nWait on the last wait edge so it is low exactly N cycles
                    cnt_d   = cnt_q - 4'd1;
                    nwait_d = (cnt_q == 4'd1);
                end else begin
                    if (is_rd_q) din_d = SramDin;
                    nce_d   = 1'b1;
                    noe_d   = 1'b1;
                    nwe_d   = 1'b1;
                    nwait_d = 1'b1;
                end
            end
            S_HOLD: if (ALE) err_d = 1'b1;
            default: ;
        endcase
    end

    assign CoreDataIn = din_q;
    assign nWait      = nwait_q;
    assign SramAddr   = addr_q;
    assign SramDout   = dout_q;
    assign SramnCE    = nce_q;
    assign SramnOE    = noe_q;
    assign SramnWE    = nwe_q;
    assign BusErr     = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - scoreboard bench for mem_bus_ctrl with a behavioural SRAM and bus model
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

    localparam int AW  = 16;
    localparam int RDW = 2;
    localparam int WRW = 0;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic [15:0]   CoreData = 16'h0000;
    logic          ALE = 1'b0, nME = 1'b1, nOE = 1'b1, RnW = 1'b1;
    logic [15:0]   CoreDataIn;
    logic          nWait;
    logic [AW-1:0] SramAddr;
    logic [15:0]   SramDout;
    logic [15:0]   SramDin = 16'h0000;
    logic          SramnCE, SramnOE, SramnWE, BusErr;

    always #5 Clock = ~Clock;

    mem_bus_ctrl #(.ADDR_W(AW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
        .Clock(Clock), .nReset(nReset), .CoreData(CoreData), .ALE(ALE),
        .nME(nME), .nOE(nOE), .RnW(RnW), .CoreDataIn(CoreDataIn), .nWait(nWait),
        .SramAddr(SramAddr), .SramDout(SramDout), .SramDin(SramDin),
        .SramnCE(SramnCE), .SramnOE(SramnOE), .SramnWE(SramnWE), .BusErr(BusErr)
    );

    typedef struct {
        logic [15:0] addr;
        bit          rd;
        logic [15:0] data;
        int          len;
        int          nw;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] sram[int];
    logic [15:0] ref_mem[int];
    logic [15:0] last_rd = 16'h0000;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [15:0] pat(int a);
        logic [15:0] k;
        k = 16'hC3A5;
        return 16'(a) ^ k;
    endfunction

    function automatic logic [15:0] ref_rd(int a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // asynchronous SRAM: write commits at the edge that ends the write strobe
    initial forever begin
        @(posedge Clock);
        if (nReset && !SramnCE && !SramnWE) sram[int'(SramAddr)] = SramDout;
    end

    initial forever begin
        @(negedge Clock);
        SramDin = sram.exists(int'(SramAddr)) ? sram[int'(SramAddr)] : pat(int'(SramAddr));
    end

    // monitor: measure each SRAM strobe window and compare when it closes
    initial begin
        int   m_len, m_nw, m_oe, m_we;
        bit   prev_nce;
        exp_t e;
        m_len = 0; m_nw = 0; m_oe = 0; m_we = 0; prev_nce = 1'b1;
        forever begin
            @(negedge Clock);
            if (!nReset) begin
                m_len = 0; m_nw = 0; m_oe = 0; m_we = 0; prev_nce = 1'b1;
            end else begin
                if (!SramnCE) begin
                    m_len++;
                    if (!nWait)   m_nw++;
                    if (!SramnOE) m_oe++;
                    if (!SramnWE) m_we++;
                end else if (!prev_nce) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_access", 32'(SramAddr), 32'hFFFF_FFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk("acc_addr", 32'(SramAddr), 32'(e.addr));
                        chk("acc_len", 32'(m_len), 32'(e.len));
                        chk("acc_nwait_cycles", 32'(m_nw), 32'(e.nw));
                        chk("acc_noe_cycles", 32'(m_oe), e.rd ? 32'(e.len) : 32'd0);
                        chk("acc_nwe_cycles", 32'(m_we), e.rd ? 32'd0 : 32'(e.len));
                        if (e.rd) chk("rd_data", 32'(CoreDataIn), 32'(e.data));
                        else      chk("wr_data", 32'(SramDout), 32'(e.data));
                    end
                    m_len = 0; m_nw = 0; m_oe = 0; m_we = 0;
                end
                prev_nce = SramnCE;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_CoreDataIn", 32'(CoreDataIn), 32'h0);
        chk("rst_nWait", 32'(nWait), 32'h1);
        chk("rst_SramAddr", 32'(SramAddr), 32'h0);
        chk("rst_SramDout", 32'(SramDout), 32'h0);
        chk("rst_SramnCE", 32'(SramnCE), 32'h1);
        chk("rst_SramnOE", 32'(SramnOE), 32'h1);
        chk("rst_SramnWE", 32'(SramnWE), 32'h1);
        chk("rst_BusErr", 32'(BusErr), 32'h0);
    endtask

    task automatic do_reset();
        nReset = 1'b0; ALE = 1'b0; nME = 1'b1; nOE = 1'b1; RnW = 1'b1;
        tick();
        chk_reset();
        nReset = 1'b1;
        last_rd = 16'h0000;
        tick();
    endtask

    task automatic ale(input logic [15:0] a);
        ALE = 1'b1;
        CoreData = a;
        tick();
        ALE = 1'b0;
    endtask

    // data phase from ADDR; the expected record is pushed here, ahead of the DUT response
    task automatic access(input logic [15:0] a, input bit rd, input logic [15:0] d,
                          input int hold_extra, input bit ale_mid);
        int   t;
        exp_t e;
        e.addr = a; e.rd = rd;
        if (rd) begin
            e.data = ref_rd(int'(a)); e.len = RDW + 1; e.nw = RDW;
            last_rd = e.data;
        end else begin
            ref_mem[int'(a)] = d;
            e.data = d; e.len = WRW + 1; e.nw = WRW;
        end
        sbq.push_back(e);
        nME = 1'b0; nOE = !rd; RnW = rd;
        CoreData = rd ? 16'($urandom) : d;
        tick();
        if (ale_mid) begin
            ALE = 1'b1; CoreData = 16'hFFFF;
            tick();
            ALE = 1'b0;
        end
        t = 0;
        while (SramnCE == 1'b0 && t < 40) begin
            tick();
            t++;
        end
        if (t >= 40) chk("access_timeout", 32'(t), 32'd0);
        repeat (hold_extra) tick();
        chk("hold_data_stable", 32'(CoreDataIn), 32'(last_rd));
        nME = 1'b1; nOE = 1'b1; RnW = 1'b1;
        tick();
    endtask

    initial begin
        logic [15:0] a, d;
        bit          rd;
        exp_t        e;

        repeat (3) @(posedge Clock);
        #1;
        chk_reset();
        nReset = 1'b1;
        tick();

        // directed: write then read back, plus a zero-wait write
        ale(16'h1234); access(16'h1234, 1'b0, 16'hBEEF, 0, 1'b0);
        ale(16'h1234); access(16'h1234, 1'b1, 16'h0000, 1, 1'b0);
        ale(16'h00F0); access(16'h00F0, 1'b0, 16'hA5A5, 0, 1'b0);
        chk("no_err_directed", 32'(BusErr), 32'h0);

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            a  = 16'($urandom_range(0, 15));
            d  = 16'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            if ($urandom_range(0, 3) == 0) ale(16'($urandom));
            ale(a);
            access(a, rd, d, int'($urandom_range(0, 2)), 1'b0);
        end
        chk("no_err_random", 32'(BusErr), 32'h0);

`ifdef MEM_BUS_TIMEOUT_EN
        ale(16'h0033);
        repeat (14) tick();
        chk("tmo_not_yet", 32'(BusErr), 32'h0);
        tick();
        chk("tmo_buserr", 32'(BusErr), 32'h1);
        ale(16'h0033); access(16'h0033, 1'b1, 16'h0000, 0, 1'b0);
`else
        ale(16'h0033);
        repeat (20) tick();
        chk("addr_wait_no_err", 32'(BusErr), 32'h0);
        access(16'h0033, 1'b1, 16'h0000, 0, 1'b0);
`endif
        do_reset();

        // read requested without output enable
        ale(16'h0055);
        nME = 1'b0; RnW = 1'b1; nOE = 1'b1;
        tick();
        chk("noe_err_buserr", 32'(BusErr), 32'h1);
        chk("noe_err_nce", 32'(SramnCE), 32'h1);
        chk("noe_err_noe", 32'(SramnOE), 32'h1);
        nME = 1'b1;
        tick();
        do_reset();

        // ALE pulse during ACCESS: address kept, access completes, error flagged
        ale(16'h0007); access(16'h0007, 1'b1, 16'h0000, 0, 1'b1);
        chk("ale_mid_addr", 32'(SramAddr), 32'h0007);
        chk("ale_mid_buserr", 32'(BusErr), 32'h1);
        do_reset();

        // core abort after one wait cycle
        ale(16'h0009); access(16'h0009, 1'b1, 16'h0000, 0, 1'b0);
        ale(16'h000A);
        e.addr = 16'h000A; e.rd = 1'b1; e.data = last_rd; e.len = 1; e.nw = 1;
        sbq.push_back(e);
        nME = 1'b0; nOE = 1'b0; RnW = 1'b1;
        tick();
        nME = 1'b1; nOE = 1'b1;
        tick();
        chk("abort_nce", 32'(SramnCE), 32'h1);
        chk("abort_noe", 32'(SramnOE), 32'h1);
        chk("abort_nwait", 32'(nWait), 32'h1);
        chk("abort_buserr", 32'(BusErr), 32'h1);
        chk("abort_din_kept", 32'(CoreDataIn), 32'(last_rd));
        ale(16'h000B); access(16'h000B, 1'b1, 16'h0000, 0, 1'b0);
        do_reset();

        // asynchronous reset in the middle of a write strobe
        ale(16'h0042);
        nME = 1'b0; RnW = 1'b0; nOE = 1'b1; CoreData = 16'h1357;
        tick();
        chk("pre_reset_nwe", 32'(SramnWE), 32'h0);
        #2 nReset = 1'b0;
        #1 chk_reset();
        nME = 1'b1; RnW = 1'b1;
        tick();
        nReset = 1'b1;
        tick();
        ale(16'h0042); access(16'h0042, 1'b1, 16'h0000, 0, 1'b0);

        repeat (5) tick();
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
